// File: rtl/raider_spi_pkg.sv
// Shared types and constants for the SPI host target front-end.
// State encoding, fill byte and byte counter width.
package raider_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_e;

  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;
  localparam int         BYTE_CNT_W    = 16;

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer for one host pin plus edge detect.
// Edges are taken between the last stage and its delayed copy.
module spi_pin_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_prev;

  // Shift the pad level in and keep the previous synced value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {N{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_q    = r_sync[N-1];
  assign o_rise = r_sync[N-1] & ~r_prev;
  assign o_fall = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/spi_host_target.sv
// SPI mode-0 target: oversampled host pins, byte RX/TX paths,
// transaction framing events for the command decoder.
module spi_host_target
  import raider_spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_clk,
  input  logic                  h_cs_n,
  input  logic                  h_mosi,
  output logic                  h_miso,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  cs_active,
  output logic                  txn_start,
  output logic                  txn_end,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  tx_underrun,
  output logic                  frame_error
);

  logic w_unused_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .i_d(h_clk),
    .o_q(w_unused_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .i_d(h_cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .i_d(h_mosi),
    .o_q(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_e                r_state, w_state_nxt;
  logic [SYNC_STAGES:0]  r_warm;
  logic [2:0]            r_bit, w_bit_nxt;
  logic [7:0]            r_rx_shift, w_rx_shift_nxt;
  logic [7:0]            r_tx_shift, w_tx_shift_nxt;
  logic [7:0]            r_hold, w_hold_nxt;
  logic                  r_hold_full, w_hold_full_nxt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]            r_rx_data, w_rx_data_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_rx_first, w_rx_first_nxt;
  logic                  r_start, w_start_nxt;
  logic                  r_end, w_end_nxt;
  logic                  r_under, w_under_nxt;
  logic                  r_ferr, w_ferr_nxt;
  logic                  r_miso, w_miso_nxt;
  logic                  w_warm, w_hs, w_load;

  // Synced CS# is only trusted once the reset values have drained
  // out of the synchronizer, so a CS# held low through reset is seen.
  assign w_warm = r_warm[SYNC_STAGES];
  assign w_hs   = tx_valid & tx_ready;

  // Next state, datapath and event pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_nxt       = r_bit;
    w_rx_shift_nxt  = r_rx_shift;
    w_tx_shift_nxt  = r_tx_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_rx_first_nxt  = 1'b0;
    w_start_nxt     = 1'b0;
    w_end_nxt       = 1'b0;
    w_under_nxt     = 1'b0;
    w_ferr_nxt      = 1'b0;
    w_load          = 1'b0;
    if (w_hs) begin
      w_hold_nxt      = tx_data;
      w_hold_full_nxt = 1'b1;
    end
    unique case (r_state)
      WAIT_IDLE: begin
        if (w_warm && w_cs_q) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt    = ACTIVE;
          w_start_nxt    = 1'b1;
          w_bit_nxt      = 3'd0;
          w_byte_cnt_nxt = '0;
          w_load         = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt     = IDLE;
          w_end_nxt       = 1'b1;
          w_ferr_nxt      = (r_bit != 3'd0);
          w_bit_nxt       = 3'd0;
          w_hold_full_nxt = 1'b0;
        end else if (w_sck_rise) begin
          w_rx_shift_nxt = {r_rx_shift[6:0], w_mosi};
          w_bit_nxt      = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_rx_data_nxt  = {r_rx_shift[6:0], w_mosi};
            w_rx_valid_nxt = 1'b1;
            w_rx_first_nxt = (r_byte_cnt == '0);
            if (r_byte_cnt != '1) w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          end
        end else if (w_sck_fall) begin
          if (r_bit == 3'd0) w_load = 1'b1;
          else w_tx_shift_nxt = {r_tx_shift[6:0], 1'b1};
        end
      end
      default: w_state_nxt = WAIT_IDLE;
    endcase
    if (w_load) begin
      if (r_hold_full) begin
        w_tx_shift_nxt  = r_hold;
        w_hold_full_nxt = 1'b0;
      end else if (w_hs) begin
        w_tx_shift_nxt  = tx_data;
        w_hold_full_nxt = 1'b0;
      end else begin
        w_tx_shift_nxt = SPI_FILL_BYTE;
        w_under_nxt    = 1'b1;
      end
    end
    w_miso_nxt = (w_state_nxt == ACTIVE) ? w_tx_shift_nxt[7] : IDLE_MISO;
  end

  // Register state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_IDLE;
      r_warm      <= '0;
      r_bit       <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_tx_shift  <= SPI_FILL_BYTE;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_byte_cnt  <= '0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_start     <= 1'b0;
      r_end       <= 1'b0;
      r_under     <= 1'b0;
      r_ferr      <= 1'b0;
      r_miso      <= IDLE_MISO;
    end else begin
      r_state     <= w_state_nxt;
      r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      r_bit       <= w_bit_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_first  <= w_rx_first_nxt;
      r_start     <= w_start_nxt;
      r_end       <= w_end_nxt;
      r_under     <= w_under_nxt;
      r_ferr      <= w_ferr_nxt;
      r_miso      <= w_miso_nxt;
    end
  end

  assign h_miso      = r_miso;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_first    = r_rx_first;
  assign tx_ready    = !r_hold_full && (r_state != WAIT_IDLE);
  assign cs_active   = (r_state == ACTIVE);
  assign txn_start   = r_start;
  assign txn_end     = r_end;
  assign byte_count  = r_byte_cnt;
  assign tx_underrun = r_under;
  assign frame_error = r_ferr;

endmodule

// File: tb/tb_spi_host_target.sv
// Scoreboard bench for spi_host_target: a bit-banged SPI host,
// RX bytes checked by a negedge monitor against a queue.
module tb_spi_host_target;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_clk = 1'b0;
  logic        h_cs_n = 1'b1;
  logic        h_mosi = 1'b0;
  logic        h_miso;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_first;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, cs_active, txn_start, txn_end;
  logic [15:0] byte_count;
  logic        tx_underrun, frame_error;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_rxv = 0, cnt_start = 0, cnt_end = 0;
  int cnt_under = 0, cnt_ferr = 0, cnt_ferr_end = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_e;

  spi_host_target #(.SYNC_STAGES(2), .IDLE_MISO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi), .h_miso(h_miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cs_active(cs_active), .txn_start(txn_start), .txn_end(txn_end),
    .byte_count(byte_count), .tx_underrun(tx_underrun),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pop scoreboard on rx_valid, count event pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        cnt_rxv++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: got first=%0b data=%h, none expected",
                   rx_first, rx_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({rx_first, rx_data} !== exp_e) begin
            n_fail++;
            $display("FAIL rx_byte: got first=%0b data=%h, want first=%0b data=%h",
                     rx_first, rx_data, exp_e[8], exp_e[7:0]);
          end
        end
      end
      if (txn_start) cnt_start++;
      if (txn_end) cnt_end++;
      if (tx_underrun) cnt_under++;
      if (frame_error) cnt_ferr++;
      if (frame_error && txn_end) cnt_ferr_end++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nb,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      h_mosi = mo[7-i];
      cyc(HALF);
      mi = {mi[6:0], h_miso};
      h_clk = 1'b1;
      cyc(HALF);
      h_clk = 1'b0;
    end
  endtask

  task automatic offer(input logic [7:0] d, output logic ok);
    tx_data  = d;
    tx_valid = 1'b1;
    ok = tx_ready;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    cyc(2);
    n_chk++;
    if (h_miso !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_miso: got %b want 1", h_miso);
    end
    n_chk++;
    if ({rx_data, rx_valid, rx_first, tx_ready, cs_active} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_rx: got %h want 000",
               {rx_data, rx_valid, rx_first, tx_ready, cs_active});
    end
    n_chk++;
    if ({txn_start, txn_end, byte_count, tx_underrun, frame_error} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_evt: got %h want 00000",
               {txn_start, txn_end, byte_count, tx_underrun, frame_error});
    end
  endtask

  task automatic test_basic;
    logic ok;
    logic [7:0] mi;
    int s0, e0;
    rst = 1'b0;
    cyc(6);
    n_chk++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tx_ready: got %b want 1", tx_ready);
    end
    offer(8'hC2, ok);
    n_chk++;
    if (ok !== 1'b1 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL preload: accepted=%b ready=%b want 1/0", ok, tx_ready);
    end
    s0 = cnt_start;
    e0 = cnt_end;
    exp_q.push_back({1'b1, 8'h9F});
    h_cs_n = 1'b0;
    cyc(8);
    spi_bits(8'h9F, 8, mi);
    n_chk++;
    if (mi !== 8'hC2) begin
      n_fail++;
      $display("FAIL basic_miso: got %h want c2", mi);
    end
    cyc(4);
    h_cs_n = 1'b1;
    cyc(6);
    n_chk++;
    if (byte_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 1", byte_count);
    end
    n_chk++;
    if (cnt_start !== s0 + 1 || cnt_end !== e0 + 1) begin
      n_fail++;
      $display("FAIL basic_frame: starts=%0d ends=%0d want %0d/%0d",
               cnt_start - s0, cnt_end - e0, 1, 1);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_rx_missing: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_multi;
    logic ok0, ok1, ok2;
    logic [7:0] m0, m1, m2;
    int u0;
    u0 = cnt_under;
    exp_q.push_back({1'b1, 8'h03});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    h_cs_n = 1'b0;
    cyc(8);
    spi_bits(8'h03, 8, m0);
    offer(8'hAA, ok0);
    spi_bits(8'h12, 8, m1);
    offer(8'h55, ok1);
    spi_bits(8'h34, 8, m2);
    offer(8'h00, ok2);
    cyc(4);
    n_chk++;
    if (cnt_under !== u0 + 1) begin
      n_fail++;
      $display("FAIL multi_underrun: got %0d want 1", cnt_under - u0);
    end
    h_cs_n = 1'b1;
    cyc(6);
    n_chk++;
    if ({m0, m1, m2} !== 24'hFFAA55) begin
      n_fail++;
      $display("FAIL multi_miso: got %h want ffaa55", {m0, m1, m2});
    end
    n_chk++;
    if ({ok0, ok1, ok2} !== 3'b111) begin
      n_fail++;
      $display("FAIL multi_accept: got %b want 111", {ok0, ok1, ok2});
    end
    n_chk++;
    if (byte_count !== 16'd3) begin
      n_fail++;
      $display("FAIL multi_count: got %0d want 3", byte_count);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL multi_rx_missing: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_frame_error;
    logic [7:0] mi;
    int v0, f0, fe0;
    v0  = cnt_rxv;
    f0  = cnt_ferr;
    fe0 = cnt_ferr_end;
    h_cs_n = 1'b0;
    cyc(8);
    spi_bits(8'hA5, 5, mi);
    cyc(3);
    h_cs_n = 1'b1;
    cyc(6);
    n_chk++;
    if (cnt_ferr !== f0 + 1 || cnt_ferr_end !== fe0 + 1) begin
      n_fail++;
      $display("FAIL frame_err: ferr=%0d with_end=%0d want 1/1",
               cnt_ferr - f0, cnt_ferr_end - fe0);
    end
    n_chk++;
    if (cnt_rxv !== v0) begin
      n_fail++;
      $display("FAIL frame_rx: got %0d rx_valid want 0", cnt_rxv - v0);
    end
    n_chk++;
    if (byte_count !== 16'd0) begin
      n_fail++;
      $display("FAIL frame_count: got %0d want 0", byte_count);
    end
  endtask

  task automatic test_reset_cs_low;
    int s0, v0, k;
    rst = 1'b1;
    h_cs_n = 1'b0;
    cyc(2);
    rst = 1'b0;
    s0 = cnt_start;
    v0 = cnt_rxv;
    for (int i = 0; i < 8; i++) begin
      h_mosi = i[0];
      h_clk = 1'b1;
      cyc(4);
      n_chk++;
      if (tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL waitidle_ready: got %b want 0 (sck %0d)", tx_ready, i);
      end
      h_clk = 1'b0;
      cyc(4);
    end
    n_chk++;
    if (cnt_start !== s0 || cnt_rxv !== v0) begin
      n_fail++;
      $display("FAIL waitidle_events: starts=%0d rx=%0d want 0/0",
               cnt_start - s0, cnt_rxv - v0);
    end
    h_cs_n = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    n_chk++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waitidle_exit: tx_ready=%b want 1 within 20 cycles", tx_ready);
    end
    h_cs_n = 1'b0;
    cyc(5);
    n_chk++;
    if (cnt_start !== s0 + 1 || cs_active !== 1'b1) begin
      n_fail++;
      $display("FAIL waitidle_start: starts=%0d active=%b want 1/1",
               cnt_start - s0, cs_active);
    end
    h_cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic test_bypass;
    logic [7:0] mi;
    int u0;
    u0 = cnt_under;
    h_cs_n = 1'b0;
    cyc(2);
    n_chk++;
    if (txn_start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early: got %b want 0 at 2 cycles", txn_start);
    end
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    n_chk++;
    if (txn_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: got %b want 1 at 3 cycles", txn_start);
    end
    n_chk++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_hold: tx_ready=%b want 1", tx_ready);
    end
    cyc(4);
    n_chk++;
    if (cnt_under !== u0) begin
      n_fail++;
      $display("FAIL bypass_underrun: got %0d want 0", cnt_under - u0);
    end
    exp_q.push_back({1'b1, 8'h66});
    spi_bits(8'h66, 8, mi);
    n_chk++;
    if (mi !== 8'h5A) begin
      n_fail++;
      $display("FAIL bypass_miso: got %h want 5a", mi);
    end
    cyc(4);
    h_cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    h_cs_n = 1'b0;
    cyc(8);
    spi_bits(8'hE7, 3, mi);
    cyc(2);
    n_chk++;
    if (cs_active !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_active: got %b want 1", cs_active);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (h_miso !== 1'b1 || cs_active !== 1'b0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: miso=%b active=%b ready=%b want 1/0/0",
               h_miso, cs_active, tx_ready);
    end
    n_chk++;
    if ({rx_data, rx_valid, rx_first, txn_start, txn_end, byte_count,
         tx_underrun, frame_error} !== 30'h0) begin
      n_fail++;
      $display("FAIL mid_reset_regs: got %h want 0",
               {rx_data, rx_valid, rx_first, txn_start, txn_end, byte_count,
                tx_underrun, frame_error});
    end
    cyc(2);
    h_cs_n = 1'b1;
    rst = 1'b0;
    cyc(8);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_multi;
    test_frame_error;
    test_reset_cs_low;
    test_bypass;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
